shreg_universal: RTL and testbench

Parametrised universal shift register that replaces the fixed 4-bit load/shift-left register. It supports parallel load, logical and arithmetic shifts, rotates, serial in/out, and multi-step shift commands. A start/busy/done handshake runs each command, with abort support. It sits between serial links and parallel datapaths, and serves as a serialiser/deserialiser and barrel-shift helper.

---
 rtl/shreg_pkg.sv | 30 +++
 rtl/shreg_step.sv | 46 ++++
 rtl/shreg_universal.sv | 101 ++++++++++
 tb/tb_shreg_universal.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/shreg_pkg.sv
// Shared types and helpers for the universal shift register.
// Holds the operation and FSM enums plus the shift-count clamp.
package shreg_pkg;

   typedef enum logic [2:0] {
      HOLD = 3'd0,
      LOAD = 3'd1,
      SHL  = 3'd2,
      SHR  = 3'd3,
      ROL  = 3'd4,
      ROR  = 3'd5,
      ASR  = 3'd6,
      RSVD = 3'd7
   } mode_e;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_e;

   // Shifting more than the register width is pointless, so saturate.
   function automatic int clamp_amt(input int amt, input int width);
      return (amt > width) ? width : amt;
   endfunction

   function automatic logic is_shift(input mode_e m);
      return (m == SHL) || (m == SHR) || (m == ROL) || (m == ROR) || (m == ASR);
   endfunction

endpackage

// File: rtl/shreg_step.sv
// Combinational single-step next-value calculator.
// Non-shift modes pass q through; their sout value is ignored by the top.
module shreg_step
   import shreg_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic [WIDTH-1:0] q,
   input  mode_e            mode,
   input  logic             sin,
   output logic [WIDTH-1:0] q_next,
   output logic             sout_next
);

   always_comb begin
      q_next    = q;
      sout_next = 1'b0;
      case (mode)
         SHL: begin
            q_next    = {q[WIDTH-2:0], sin};
            sout_next = q[WIDTH-1];
         end
         SHR: begin
            q_next    = {sin, q[WIDTH-1:1]};
            sout_next = q[0];
         end
         ROL: begin
            q_next    = {q[WIDTH-2:0], q[WIDTH-1]};
            sout_next = q[WIDTH-1];
         end
         ROR: begin
            q_next    = {q[0], q[WIDTH-1:1]};
            sout_next = q[0];
         end
         ASR: begin
            q_next    = {q[WIDTH-1], q[WIDTH-1:1]};
            sout_next = q[0];
         end
         default: begin
            q_next    = q;
            sout_next = 1'b0;
         end
      endcase
   end

endmodule

// File: rtl/shreg_universal.sv
// Universal shift register with start/busy/done handshake and abort.
// The first step happens on the accepting edge; RUN covers the remaining steps.
module shreg_universal
   import shreg_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int AW    = $clog2(WIDTH) + 1
) (
   input  logic             c,
   input  logic             rst_n,
   input  logic             start,
   input  logic [2:0]       mode,
   input  logic [AW-1:0]    amt,
   input  logic [WIDTH-1:0] d,
   input  logic             sin,
   input  logic             abort,
   output logic [WIDTH-1:0] q,
   output logic             sout,
   output logic             busy,
   output logic             done
);

   state_e          state;
   mode_e           run_mode;
   mode_e           in_mode;
   mode_e           step_mode;
   logic [AW-1:0]   remaining;
   logic [AW-1:0]   n_amt;
   logic [WIDTH-1:0] step_q;
   logic            step_sout;

   assign in_mode   = mode_e'(mode);
   assign n_amt     = AW'(clamp_amt(int'(amt), WIDTH));
   // The step unit sees the live mode when accepting, the latched one while running.
   assign step_mode = (state == IDLE) ? in_mode : run_mode;

   shreg_step #(.WIDTH(WIDTH)) u_step (
      .q         (q),
      .mode      (step_mode),
      .sin       (sin),
      .q_next    (step_q),
      .sout_next (step_sout)
   );

   always_ff @(posedge c) begin
      if (!rst_n) begin
         q         <= '0;
         sout      <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
         remaining <= '0;
         run_mode  <= HOLD;
         state     <= IDLE;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  if (in_mode == LOAD) begin
                     q    <= d;
                     done <= 1'b1;
                  end else if (is_shift(in_mode) && (n_amt != '0)) begin
                     q        <= step_q;
                     sout     <= step_sout;
                     run_mode <= in_mode;
                     if (n_amt == AW'(1)) begin
                        done <= 1'b1;
                     end else begin
                        remaining <= n_amt - AW'(1);
                        busy      <= 1'b1;
                        state     <= RUN;
                     end
                  end else begin
                     done <= 1'b1;
                  end
               end
            end
            RUN: begin
               if (abort) begin
                  busy      <= 1'b0;
                  remaining <= '0;
                  state     <= IDLE;
               end else begin
                  q    <= step_q;
                  sout <= step_sout;
                  if (remaining == AW'(1)) begin
                     remaining <= '0;
                     busy      <= 1'b0;
                     done      <= 1'b1;
                     state     <= IDLE;
                  end else begin
                     remaining <= remaining - AW'(1);
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_shreg_universal.sv
// Scoreboard bench for shreg_universal (WIDTH=8) using hand-computed vectors.
// Stimulus queues the expected post-edge outputs; a monitor checks them 1ns after each edge.
module tb_shreg_universal;

   localparam int WIDTH = 8;
   localparam int AW    = $clog2(WIDTH) + 1;

   logic             c;
   logic             rst_n;
   logic             start;
   logic [2:0]       mode;
   logic [AW-1:0]    amt;
   logic [WIDTH-1:0] d;
   logic             sin;
   logic             abort;
   logic [WIDTH-1:0] q;
   logic             sout;
   logic             busy;
   logic             done;

   typedef struct {
      logic [WIDTH-1:0] q;
      logic             sout;
      logic             busy;
      logic             done;
      string            name;
   } exp_t;

   exp_t exp_q[$];
   int   checks;
   int   failures;

   shreg_universal #(.WIDTH(WIDTH)) dut (
      .c     (c),
      .rst_n (rst_n),
      .start (start),
      .mode  (mode),
      .amt   (amt),
      .d     (d),
      .sin   (sin),
      .abort (abort),
      .q     (q),
      .sout  (sout),
      .busy  (busy),
      .done  (done)
   );

   initial c = 1'b0;
   always #5 c = ~c;

   task automatic checkOutput(input exp_t e);
      checks++;
      if (q !== e.q || sout !== e.sout || busy !== e.busy || done !== e.done) begin
         failures++;
         $display("[TB] FAIL %s: got q=%h sout=%b busy=%b done=%b, expected q=%h sout=%b busy=%b done=%b",
                  e.name, q, sout, busy, done, e.q, e.sout, e.busy, e.done);
      end
   endtask

   always @(posedge c) begin
      #1;
      if (exp_q.size() > 0) checkOutput(exp_q.pop_front());
   end

   // Drive one cycle of inputs and queue the outputs expected after the next edge.
   task automatic applyStimulus(input logic r, input logic st, input logic [2:0] md,
                                input logic [AW-1:0] am, input logic [7:0] dd,
                                input logic si, input logic ab,
                                input logic [7:0] eq, input logic es, input logic eb,
                                input logic ed, input string nm);
      exp_t e;
      @(negedge c);
      rst_n = r; start = st; mode = md; amt = am; d = dd; sin = si; abort = ab;
      e.q = eq; e.sout = es; e.busy = eb; e.done = ed; e.name = nm;
      exp_q.push_back(e);
   endtask

   task automatic idleCheck(input logic [7:0] eq, input logic es, input string nm);
      applyStimulus(1, 0, 3'd0, 4'd0, 8'h00, 0, 0, eq, es, 0, 0, nm);
   endtask

   logic [7:0] ror_q[8] = '{8'h97, 8'hCB, 8'hE5, 8'hF2, 8'h79, 8'hBC, 8'h5E, 8'h2F};
   logic       ror_s[8] = '{1, 1, 1, 1, 0, 1, 0, 0};

   initial begin
      int wait_cycles;
      logic [AW-1:0] ror_amt;
      checks = 0; failures = 0;
      rst_n = 0; start = 0; mode = 0; amt = 0; d = 0; sin = 0; abort = 0;

      applyStimulus(0, 1, 3'd1, 4'd0, 8'hFF, 0, 0, 8'h00, 0, 0, 0, "reset1");
      applyStimulus(0, 1, 3'd1, 4'd0, 8'hFF, 0, 0, 8'h00, 0, 0, 0, "reset2");

      applyStimulus(1, 1, 3'd1, 4'd0, 8'hA5, 0, 0, 8'hA5, 0, 0, 1, "load_a5");
      idleCheck(8'hA5, 0, "load_idle");

      applyStimulus(1, 1, 3'd2, 4'd3, 8'h00, 1, 0, 8'h4B, 1, 1, 0, "shl_1");
      applyStimulus(1, 0, 3'd0, 4'd0, 8'h00, 1, 0, 8'h97, 0, 1, 0, "shl_2");
      applyStimulus(1, 0, 3'd0, 4'd0, 8'h00, 1, 0, 8'h2F, 1, 0, 1, "shl_3");
      idleCheck(8'h2F, 1, "shl_idle");

      // Two back-to-back ROR commands: amt=8, then amt=12 clamped to 8.
      for (int r = 0; r < 2; r++) begin
         ror_amt = (r == 0) ? 4'd8 : 4'd12;
         for (int i = 0; i < 8; i++) begin
            applyStimulus(1, (i == 0), 3'd5, ror_amt, 8'h00, 0, 0,
                          ror_q[i], ror_s[i], (i < 7), (i == 7),
                          $sformatf("ror_r%0d_s%0d", r, i));
         end
      end
      idleCheck(8'h2F, 0, "ror_idle");

      applyStimulus(1, 1, 3'd1, 4'd0, 8'h90, 0, 0, 8'h90, 0, 0, 1, "load_90");
      applyStimulus(1, 1, 3'd6, 4'd2, 8'h00, 0, 0, 8'hC8, 0, 1, 0, "asr_1");
      applyStimulus(1, 0, 3'd0, 4'd0, 8'h00, 0, 0, 8'hE4, 0, 0, 1, "asr_2");

      applyStimulus(1, 1, 3'd1, 4'd0, 8'hFF, 0, 0, 8'hFF, 0, 0, 1, "load_ff");
      applyStimulus(1, 1, 3'd3, 4'd5, 8'h00, 0, 0, 8'h7F, 1, 1, 0, "shr_1");
      applyStimulus(1, 0, 3'd0, 4'd0, 8'h00, 0, 0, 8'h3F, 1, 1, 0, "shr_2");
      applyStimulus(1, 0, 3'd0, 4'd0, 8'h00, 0, 1, 8'h3F, 1, 0, 0, "shr_abort");
      idleCheck(8'h3F, 1, "abort_idle");

      // Start during RUN (with different mode/amt/d) must be ignored.
      applyStimulus(1, 1, 3'd4, 4'd3, 8'h00, 0, 0, 8'h7E, 0, 1, 0, "rol_1");
      applyStimulus(1, 1, 3'd1, 4'd1, 8'h00, 1, 0, 8'hFC, 0, 1, 0, "rol_2_ign_start");
      applyStimulus(1, 0, 3'd0, 4'd0, 8'h00, 0, 0, 8'hF9, 1, 0, 1, "rol_3");

      applyStimulus(1, 1, 3'd2, 4'd1, 8'h00, 0, 0, 8'hF2, 1, 0, 1, "shl_amt1");
      applyStimulus(1, 1, 3'd7, 4'd3, 8'h11, 1, 0, 8'hF2, 1, 0, 1, "reserved");
      applyStimulus(1, 1, 3'd0, 4'd3, 8'h11, 1, 0, 8'hF2, 1, 0, 1, "hold");
      applyStimulus(1, 1, 3'd5, 4'd0, 8'h11, 1, 0, 8'hF2, 1, 0, 1, "ror_amt0");
      applyStimulus(1, 1, 3'd1, 4'd0, 8'h5A, 0, 1, 8'h5A, 1, 0, 1, "load_with_abort");

      applyStimulus(1, 1, 3'd3, 4'd4, 8'h00, 1, 0, 8'hAD, 0, 1, 0, "shr_pre_reset");
      applyStimulus(0, 1, 3'd1, 4'd0, 8'hFF, 1, 0, 8'h00, 0, 0, 0, "reset_in_run");
      idleCheck(8'h00, 0, "post_reset_idle");

      wait_cycles = 0;
      while (exp_q.size() > 0 && wait_cycles < 20) begin
         @(posedge c);
         wait_cycles++;
      end
      #2;
      if (exp_q.size() > 0) begin
         failures++;
         checks++;
         $display("[TB] FAIL drain: got %0d pending, expected 0", exp_q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
